// File: rtl/gpu_video_pkg.sv
// rtl/gpu_video_pkg.sv - shared types, framebuffer geometry and default 640x480 timing for scan-out
package gpu_video_pkg;

   typedef logic [23:0] rgb24_t;

   localparam int FB_ADDR_W     = 20;
   localparam int FB_PITCH_LOG2 = 10;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   // Counters never narrower than 10 bits so the address slice is always legal.
   function automatic int cnt_width(input int total);
      return ($clog2(total) > 10) ? $clog2(total) : 10;
   endfunction

   function automatic logic [FB_ADDR_W-1:0] fb_addr(input logic [9:0] y, input logic [9:0] x);
      return (FB_ADDR_W'(y) << FB_PITCH_LOG2) | FB_ADDR_W'(x);
   endfunction

endpackage

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster h/v counters with active, sync and frame-origin flags
module video_timing_gen
   import gpu_video_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int H_CW    = cnt_width(H_TOTAL),
   localparam int V_CW    = cnt_width(V_TOTAL)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            enable,
   output logic [H_CW-1:0] h,
   output logic [V_CW-1:0] v,
   output logic            active,
   output logic            hsync_on,
   output logic            vsync_on,
   output logic            origin
);

   localparam logic [H_CW-1:0] H_LAST     = H_CW'(H_TOTAL - 1);
   localparam logic [V_CW-1:0] V_LAST     = V_CW'(V_TOTAL - 1);
   localparam logic [H_CW-1:0] HS_START   = H_CW'(H_ACTIVE + H_FP);
   localparam logic [H_CW-1:0] HS_END     = H_CW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [V_CW-1:0] VS_START   = V_CW'(V_ACTIVE + V_FP);
   localparam logic [V_CW-1:0] VS_END     = V_CW'(V_ACTIVE + V_FP + V_SYNC);

   // Disabled raster parks at the origin so re-enable always starts a fresh frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h <= '0;
         v <= '0;
      end else if (!enable) begin
         h <= '0;
         v <= '0;
      end else if (h == H_LAST) begin
         h <= '0;
         v <= (v == V_LAST) ? '0 : v + V_CW'(1);
      end else begin
         h <= h + H_CW'(1);
      end
   end

   assign active   = (h < H_CW'(H_ACTIVE)) && (v < V_CW'(V_ACTIVE));
   assign hsync_on = (h >= HS_START) && (h < HS_END);
   assign vsync_on = (v >= VS_START) && (v < VS_END);
   assign origin   = (h == '0) && (v == '0);

endmodule

// File: rtl/framebuffer_scanout.sv
// rtl/framebuffer_scanout.sv - framebuffer read addressing and 2-stage aligned video output
module framebuffer_scanout
   import gpu_video_pkg::*;
#(
   parameter int   H_ACTIVE    = DEF_H_ACTIVE,
   parameter int   H_FP        = DEF_H_FP,
   parameter int   H_SYNC      = DEF_H_SYNC,
   parameter int   H_BP        = DEF_H_BP,
   parameter int   V_ACTIVE    = DEF_V_ACTIVE,
   parameter int   V_FP        = DEF_V_FP,
   parameter int   V_SYNC      = DEF_V_SYNC,
   parameter int   V_BP        = DEF_V_BP,
   parameter logic SYNC_ACTIVE = 1'b0,
   localparam int  H_TOTAL     = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int  V_TOTAL     = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int  H_CW        = cnt_width(H_TOTAL),
   localparam int  V_CW        = cnt_width(V_TOTAL)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   output logic [FB_ADDR_W-1:0] fb_read,
   input  rgb24_t               fb_data,
   output rgb24_t               vga_rgb,
   output logic                 vga_hsync,
   output logic                 vga_vsync,
   output logic                 vga_de,
   output logic                 frame_start
);

   logic [H_CW-1:0] h;
   logic [V_CW-1:0] v;
   logic            active;
   logic            hsync_on;
   logic            vsync_on;
   logic            origin;

   logic            s1_de;
   logic            s1_hs;
   logic            s1_vs;
   logic            s1_fs;

   video_timing_gen #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP)
   ) u_timing (
      .clk      (clk),
      .rst      (rst),
      .enable   (enable),
      .h        (h),
      .v        (v),
      .active   (active),
      .hsync_on (hsync_on),
      .vsync_on (vsync_on),
      .origin   (origin)
   );

   assign fb_read = (enable && active) ? fb_addr(v[9:0], h[9:0]) : '0;

   // Stage 1 waits out the memory read latency; stage 2 pairs flags with fb_data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_de       <= 1'b0;
         s1_hs       <= 1'b0;
         s1_vs       <= 1'b0;
         s1_fs       <= 1'b0;
         vga_rgb     <= '0;
         vga_de      <= 1'b0;
         vga_hsync   <= !SYNC_ACTIVE;
         vga_vsync   <= !SYNC_ACTIVE;
         frame_start <= 1'b0;
      end else if (!enable) begin
         s1_de       <= 1'b0;
         s1_hs       <= 1'b0;
         s1_vs       <= 1'b0;
         s1_fs       <= 1'b0;
         vga_rgb     <= '0;
         vga_de      <= 1'b0;
         vga_hsync   <= !SYNC_ACTIVE;
         vga_vsync   <= !SYNC_ACTIVE;
         frame_start <= 1'b0;
      end else begin
         s1_de       <= active;
         s1_hs       <= hsync_on;
         s1_vs       <= vsync_on;
         s1_fs       <= origin;
         vga_rgb     <= s1_de ? fb_data : '0;
         vga_de      <= s1_de;
         vga_hsync   <= s1_hs ? SYNC_ACTIVE : !SYNC_ACTIVE;
         vga_vsync   <= s1_vs ? SYNC_ACTIVE : !SYNC_ACTIVE;
         frame_start <= s1_fs;
      end
   end

endmodule

// File: tb/tb_framebuffer_scanout.sv
// tb/tb_framebuffer_scanout.sv - randomized self-checking bench for framebuffer_scanout
module tb_framebuffer_scanout;

   localparam int HA = 4, HT = 8, VA = 3, VT = 6, FT = HT * VT;
   localparam int HS0 = 5, HS1 = 7, VS0 = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic [19:0] fb_read;
   logic [23:0] fb_data = '0;
   logic [23:0] vga_rgb;
   logic        vga_hsync, vga_vsync, vga_de, frame_start;
   logic        ff_mode = 1'b0;

   int compared = 0;
   int mismatched = 0;

   framebuffer_scanout #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .SYNC_ACTIVE(1'b0)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .fb_read     (fb_read),
      .fb_data     (fb_data),
      .vga_rgb     (vga_rgb),
      .vga_hsync   (vga_hsync),
      .vga_vsync   (vga_vsync),
      .vga_de      (vga_de),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   // Registered-read memory: one cycle latency.
   always @(posedge clk) fb_data <= ff_mode ? 24'hFFFFFF : {4'h0, fb_read};

   // Reference: raster position is elapsed enabled cycles mod frame length;
   // a pixel emerges two cycles later only if the run was unbroken.
   int     prev_t = 0;
   bit     prev_en = 1'b0;
   int     t_c = 0;
   int     h_t[2];
   bit     h_en[2];
   bit     h_ff[2];
   bit     cur_ff = 1'b0;
   logic [19:0] exp_fb;
   logic [23:0] exp_rgb;
   logic        exp_de, exp_hs, exp_vs, exp_fs;

   task automatic drive_cycle(input bit e, input bit r);
      int x, y, ox, oy;
      @(posedge clk);
      #1;
      enable  = e;
      rst     = r;
      ff_mode = cur_ff;
      if (r) begin
         t_c = 0;
         prev_en = 1'b0;
         h_en[0] = 1'b0;
         h_en[1] = 1'b0;
         exp_fb = '0; exp_rgb = '0; exp_de = 1'b0;
         exp_hs = 1'b1; exp_vs = 1'b1; exp_fs = 1'b0;
      end else begin
         t_c = prev_en ? (prev_t + 1) % FT : 0;
         x = t_c % HT;
         y = t_c / HT;
         exp_fb = (e && x < HA && y < VA) ? 20'(y * 1024 + x) : 20'h0;
         if (h_en[0] && h_en[1]) begin
            ox = h_t[1] % HT;
            oy = h_t[1] / HT;
            exp_de  = (ox < HA) && (oy < VA);
            exp_hs  = !((ox >= HS0) && (ox < HS1));
            exp_vs  = !(oy == VS0);
            exp_fs  = (h_t[1] == 0);
            exp_rgb = !exp_de ? 24'h0 : (h_ff[1] ? 24'hFFFFFF : 24'(oy * 1024 + ox));
         end else begin
            exp_de = 1'b0; exp_hs = 1'b1; exp_vs = 1'b1; exp_fs = 1'b0; exp_rgb = '0;
         end
         h_t[1] = h_t[0]; h_en[1] = h_en[0]; h_ff[1] = h_ff[0];
         h_t[0] = t_c;    h_en[0] = e;       h_ff[0] = cur_ff;
         prev_t = t_c;
         prev_en = e;
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      drive_cycle(1'b0, 1'b1);
      drive_cycle(1'b0, 1'b1);
      compared++;
      if ({fb_read, vga_rgb, vga_de, vga_hsync, vga_vsync, frame_start} !== {20'h0, 24'h0, 4'b0110}) begin
         mismatched++;
         $display("FAIL reset: got fb=%h rgb=%h de/hs/vs/fs=%b%b%b%b want fb=0 rgb=0 0110",
                  fb_read, vga_rgb, vga_de, vga_hsync, vga_vsync, frame_start);
      end
   endtask

   task automatic test_first_line();
      logic [19:0] seq [9];
      int fs_at = -1;
      seq = '{20'h0, 20'h1, 20'h2, 20'h3, 20'h0, 20'h0, 20'h0, 20'h0, 20'h400};
      for (int i = 0; i < 16; i++) begin
         drive_cycle(1'b1, 1'b0);
         if (frame_start === 1'b1 && fs_at < 0) fs_at = i;
         if (i < 9) begin
            compared++;
            if (fb_read !== seq[i]) begin
               mismatched++;
               $display("FAIL first_line_addr[%0d]: got %h want %h", i, fb_read, seq[i]);
            end
         end
         compared++;
         if ({fb_read, vga_rgb, vga_de, vga_hsync, vga_vsync, frame_start} !==
             {exp_fb, exp_rgb, exp_de, exp_hs, exp_vs, exp_fs}) begin
            mismatched++;
            $display("FAIL first_line[%0d]: got fb=%h rgb=%h %b%b%b%b want fb=%h rgb=%h %b%b%b%b", i,
                     fb_read, vga_rgb, vga_de, vga_hsync, vga_vsync, frame_start,
                     exp_fb, exp_rgb, exp_de, exp_hs, exp_vs, exp_fs);
         end
      end
      compared++;
      if (fs_at !== 2) begin
         mismatched++;
         $display("FAIL first_frame_start_cycle: got %0d want 2", fs_at);
      end
   endtask

   task automatic test_full_frame();
      int fs1 = -1, fs2 = -1, de_cnt = 0, vs_cnt = 0;
      for (int i = 0; i < 100; i++) begin
         drive_cycle(1'b1, 1'b0);
         if (frame_start === 1'b1) begin
            if (fs1 < 0) fs1 = i;
            else if (fs2 < 0) fs2 = i;
         end
         if (fs1 >= 0 && fs2 < 0) begin
            if (vga_de === 1'b1) de_cnt++;
            if (vga_vsync === 1'b0) vs_cnt++;
         end
         compared++;
         if ({fb_read, vga_rgb, vga_de, vga_hsync, vga_vsync, frame_start} !==
             {exp_fb, exp_rgb, exp_de, exp_hs, exp_vs, exp_fs}) begin
            mismatched++;
            $display("FAIL full_frame[%0d]: got fb=%h rgb=%h %b%b%b%b want fb=%h rgb=%h %b%b%b%b", i,
                     fb_read, vga_rgb, vga_de, vga_hsync, vga_vsync, frame_start,
                     exp_fb, exp_rgb, exp_de, exp_hs, exp_vs, exp_fs);
         end
      end
      compared++;
      if (fs2 - fs1 !== 48 || fs1 < 0) begin
         mismatched++;
         $display("FAIL frame_period: got %0d want 48", fs2 - fs1);
      end
      compared++;
      if (de_cnt !== 12) begin
         mismatched++;
         $display("FAIL de_per_frame: got %0d want 12", de_cnt);
      end
      compared++;
      if (vs_cnt !== 8) begin
         mismatched++;
         $display("FAIL vsync_cycles: got %0d want 8", vs_cnt);
      end
   endtask

   task automatic test_enable_gap();
      int guard = 0;
      while (prev_t != 9 && guard < 100) begin
         drive_cycle(1'b1, 1'b0);
         guard++;
      end
      for (int i = 0; i < 3; i++) begin
         drive_cycle(1'b0, 1'b0);
         compared++;
         if ({fb_read, vga_rgb, vga_de, vga_hsync, vga_vsync, frame_start} !==
             {exp_fb, exp_rgb, exp_de, exp_hs, exp_vs, exp_fs}) begin
            mismatched++;
            $display("FAIL enable_gap[%0d]: got fb=%h rgb=%h %b%b%b%b want fb=%h rgb=%h %b%b%b%b", i,
                     fb_read, vga_rgb, vga_de, vga_hsync, vga_vsync, frame_start,
                     exp_fb, exp_rgb, exp_de, exp_hs, exp_vs, exp_fs);
         end
      end
      for (int i = 0; i < 6; i++) begin
         drive_cycle(1'b1, 1'b0);
         if (i == 2) begin
            compared++;
            if (frame_start !== 1'b1 || vga_rgb !== 24'h0 || vga_de !== 1'b1) begin
               mismatched++;
               $display("FAIL reenable_origin: got fs=%b de=%b rgb=%h want fs=1 de=1 rgb=0",
                        frame_start, vga_de, vga_rgb);
            end
         end
         compared++;
         if ({fb_read, vga_rgb, vga_de, vga_hsync, vga_vsync, frame_start} !==
             {exp_fb, exp_rgb, exp_de, exp_hs, exp_vs, exp_fs}) begin
            mismatched++;
            $display("FAIL reenable[%0d]: got fb=%h rgb=%h %b%b%b%b want fb=%h rgb=%h %b%b%b%b", i,
                     fb_read, vga_rgb, vga_de, vga_hsync, vga_vsync, frame_start,
                     exp_fb, exp_rgb, exp_de, exp_hs, exp_vs, exp_fs);
         end
      end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b0);
      #2 rst = 1'b1;
      #1;
      compared++;
      if ({fb_read, vga_rgb, vga_de, vga_hsync, vga_vsync, frame_start} !== {20'h0, 24'h0, 4'b0110}) begin
         mismatched++;
         $display("FAIL async_reset: got fb=%h rgb=%h %b%b%b%b want fb=0 rgb=0 0110",
                  fb_read, vga_rgb, vga_de, vga_hsync, vga_vsync, frame_start);
      end
      drive_cycle(1'b1, 1'b1);
      for (int i = 0; i < 20; i++) begin
         drive_cycle(1'b1, 1'b0);
         compared++;
         if ({fb_read, vga_rgb, vga_de, vga_hsync, vga_vsync, frame_start} !==
             {exp_fb, exp_rgb, exp_de, exp_hs, exp_vs, exp_fs}) begin
            mismatched++;
            $display("FAIL after_reset[%0d]: got fb=%h rgb=%h %b%b%b%b want fb=%h rgb=%h %b%b%b%b", i,
                     fb_read, vga_rgb, vga_de, vga_hsync, vga_vsync, frame_start,
                     exp_fb, exp_rgb, exp_de, exp_hs, exp_vs, exp_fs);
         end
      end
   endtask

   task automatic test_ff_memory();
      cur_ff = 1'b1;
      for (int i = 0; i < 60; i++) begin
         drive_cycle(1'b1, 1'b0);
         if (i >= 2) begin
            compared++;
            if (vga_rgb !== (vga_de === 1'b1 ? 24'hFFFFFF : 24'h0)) begin
               mismatched++;
               $display("FAIL ff_gating[%0d]: got rgb=%h de=%b", i, vga_rgb, vga_de);
            end
         end
         compared++;
         if ({fb_read, vga_rgb, vga_de, vga_hsync, vga_vsync, frame_start} !==
             {exp_fb, exp_rgb, exp_de, exp_hs, exp_vs, exp_fs}) begin
            mismatched++;
            $display("FAIL ff_memory[%0d]: got fb=%h rgb=%h %b%b%b%b want fb=%h rgb=%h %b%b%b%b", i,
                     fb_read, vga_rgb, vga_de, vga_hsync, vga_vsync, frame_start,
                     exp_fb, exp_rgb, exp_de, exp_hs, exp_vs, exp_fs);
         end
      end
      cur_ff = 1'b0;
   endtask

   task automatic test_random();
      bit e, r;
      for (int i = 0; i < 400; i++) begin
         r = ($urandom_range(0, 59) == 0);
         e = ($urandom_range(0, 9) != 0);
         cur_ff = ($urandom_range(0, 3) == 0);
         drive_cycle(e, r);
         compared++;
         if ({fb_read, vga_rgb, vga_de, vga_hsync, vga_vsync, frame_start} !==
             {exp_fb, exp_rgb, exp_de, exp_hs, exp_vs, exp_fs}) begin
            mismatched++;
            $display("FAIL random[%0d]: got fb=%h rgb=%h %b%b%b%b want fb=%h rgb=%h %b%b%b%b", i,
                     fb_read, vga_rgb, vga_de, vga_hsync, vga_vsync, frame_start,
                     exp_fb, exp_rgb, exp_de, exp_hs, exp_vs, exp_fs);
         end
      end
      cur_ff = 1'b0;
   endtask

   initial begin
      h_t[0] = 0; h_t[1] = 0;
      h_en[0] = 1'b0; h_en[1] = 1'b0;
      h_ff[0] = 1'b0; h_ff[1] = 1'b0;
      test_reset();
      test_first_line();
      test_full_frame();
      test_enable_gap();
      test_async_reset();
      test_ff_memory();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/framebuffer_scanout.md
# framebuffer_scanout

Display scan-out stage downstream of the framebuffer memory: generates raster video timing, drives the memory's 20-bit read address with the pixel being fetched, absorbs the memory's one-cycle registered read latency, and presents aligned RGB888 plus sync/data-enable to the display PHY. Purely a reader; the memory write port belongs to the rasterizer.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line (1..1024)
- H_FP, 16, horizontal front porch clocks
- H_SYNC, 96, horizontal sync width clocks
- H_BP, 48, horizontal back porch clocks
- V_ACTIVE, 480, visible lines per frame (1..1024)
- V_FP, 10, vertical front porch lines
- V_SYNC, 2, vertical sync lines
- V_BP, 33, vertical back porch lines
- SYNC_ACTIVE, 0, asserted level of hsync/vsync

Ports:
- clk  in  1  pixel clock; sole clock
- rst  in  1  reset; asynchronous, active-high
- enable  in  1  scan-out run; low holds raster at origin, outputs blanked
- fb_read  out  20  framebuffer read address
- fb_data  in  24  framebuffer read data, valid one cycle after fb_read
- vga_rgb  out  24  pixel {R[23:16],G[15:8],B[7:0]}
- vga_hsync  out  1  horizontal sync
- vga_vsync  out  1  vertical sync
- vga_de  out  1  data enable (active pixel)
- frame_start  out  1  one-cycle pulse with first pixel of each frame

## Operation
- Counters h (0..H_TOTAL-1), v (0..V_TOTAL-1); H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, V_TOTAL likewise.
- h increments every enabled cycle; at H_TOTAL-1 wraps to 0 and v increments; v wraps to 0 after V_TOTAL-1 at h=H_TOTAL-1.
- Region order per axis: active, front porch, sync, back porch. hsync asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; vsync same rule on v (whole lines).
- active = (h < H_ACTIVE) && (v < V_ACTIVE).
- fb_read = {v[9:0], h[9:0]} when active, else 20'h0 (fixed 1024-pixel pitch).
- enable low: h=v=0 held, fb_read=0, vga_de=0, syncs deasserted (!SYNC_ACTIVE), vga_rgb=0, frame_start=0, pipeline flushed. Rising enable starts raster at (0,0) next cycle.
- Outside active, vga_rgb driven 0 regardless of fb_data.

## Timing
- Pipeline: S0 counters/fb_read (cycle N); S1 memory returns fb_data (N+1); S2 output registers load (visible at N+2).
- Pixel addressed at (x,y) appears on vga_rgb with vga_de=1 exactly 2 cycles later; hsync, vsync, de, frame_start delayed through the same 2 stages so all outputs stay aligned.
- frame_start = 1 for the single cycle vga_rgb carries pixel (0,0).
- Reset values: h=v=0, fb_read=0, vga_rgb=0, vga_de=0, vga_hsync=vga_vsync=!SYNC_ACTIVE, frame_start=0, delay pipeline cleared.
- Reset mid-frame: all state clears immediately (async); first frame after release begins at (0,0), frame_start 2 cycles after first enabled cycle.
- enable dropped mid-line: outputs blank within the next cycle; no partial pixel emitted afterward.
- Wrap: h=H_TOTAL-1,v=V_TOTAL-1 -> next cycle (0,0), no idle gap.

## Structure
- Package gpu_video_pkg: rgb24_t typedef, FB_ADDR_W=20, FB_PITCH_LOG2=10, default 640x480 timing constants.
- Sub-module video_timing_gen: h/v counters, active/hsync/vsync/frame-origin flags; framebuffer_scanout adds address generation and 2-stage alignment.

## Test plan
Small config: H_ACTIVE=4,H_FP=1,H_SYNC=2,H_BP=1 (H_TOTAL=8); V_ACTIVE=3,V_FP=1,V_SYNC=1,V_BP=1 (V_TOTAL=6); SYNC_ACTIVE=0; memory model with data = {4'h0,addr}.
- Reset then enable=1 -> fb_read sequence 0x00000,0x00001,0x00002,0x00003,0,0,0,0,0x00400...; vga_rgb 0x000000..0x000003 with de=1 on cycles 3..6 after enable; frame_start at cycle 3.
- Line 0 blanking -> vga_hsync=0 for output cycles at h=5,6 (delayed by 2); de=0 for h=4..7; vga_rgb=0 there.
- Full frame -> vsync low for all 8 cycles of v=4; de count per frame = 12; frame_start every 48 cycles.
- enable low for 3 cycles at (2,1) -> de=0, syncs high, fb_read=0; re-enable restarts at fb_read=0x00000 and frame_start 2 cycles later.
- Async rst asserted mid-line (between clock edges) -> all outputs at reset values before next edge; restart from (0,0) after release.
- Memory drives 0xFFFFFF constantly -> vga_rgb=0xFFFFFF only when de=1, 0 otherwise.
